reg_file_sb: RTL and testbench

- Register file with an integrated write scoreboard.
- Sits downstream of the single-register storage stage: it holds NREGS words of BITS bits and serves two combinational read ports and one synchronous write port.
- The scoreboard tracks destination registers that issue has reserved and writeback has not yet written, so issue logic can stall on RAW hazards.
- Register 0 is hardwired to zero.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 89 ++++++++
 rtl/reg_file_sb.sv | 97 +++++++++
 tb/tb_reg_file_sb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file, decode and writeback.
// Contents:
//   BITS_DEF / NREGS_DEF / AW_DEF : default datapath width, register count
//                                   and register index width
//   reg_idx_t                     : register index type for the default
//                                   configuration
//   REG_ZERO                      : index of the hardwired-zero register
package cpu_pkg;

    localparam int BITS_DEF  = 8;
    localparam int NREGS_DEF = 8;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Write scoreboard: one busy bit per register, set when issue reserves a
// destination and cleared when writeback writes it.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rs1_addr / rs1_busy   : read port 1 index and its pending-write flag
//   rs2_addr / rs2_busy   : read port 2 index and its pending-write flag
//   wenable, waddr        : writeback strobe and index (clears busy)
//   rsv_valid, rsv_addr   : reservation request and index (sets busy)
//   rsv_ready             : reservation would be accepted this cycle
//   pending               : registered count of busy registers
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    output logic          rs1_busy,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs2_busy,
    input  logic          wenable,
    input  logic [AW-1:0] waddr,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    output logic          rsv_ready,
    output logic [AW:0]   pending
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      pending_q;
    logic [AW:0]      pending_d;
    logic             ready_s;
    logic             rsv_acc_s;
    logic             inc_s;
    logic             dec_s;

    // Busy lookups; a write in flight to the same index hides the busy bit
    // because its data is already being bypassed.
    always_comb begin
        rs1_busy  = busy_q[rs1_addr] && !(wenable && (waddr == rs1_addr));
        rs2_busy  = busy_q[rs2_addr] && !(wenable && (waddr == rs2_addr));
        ready_s   = !busy_q[rsv_addr] || (wenable && (waddr == rsv_addr));
        // r0 reservations are accepted but never recorded.
        rsv_acc_s = rsv_valid && ready_s && (rsv_addr != ZERO_IDX);
    end

    // Next busy vector: reservation wins over a same-edge clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            busy_d[i] = (rsv_acc_s && (rsv_addr == AW'(i))) ||
                        (busy_q[i] && !(wenable && (waddr == AW'(i))));
        end
        busy_d[0] = 1'b0;
    end

    // Incremental popcount: a set of a clear bit counts up, a clear of a set
    // bit counts down; a write and reserve of the same busy register is net 0.
    always_comb begin
        inc_s = rsv_acc_s && !busy_q[rsv_addr];
        dec_s = wenable && (waddr != ZERO_IDX) && busy_q[waddr] &&
                !(rsv_acc_s && (rsv_addr == waddr));
        case ({inc_s, dec_s})
            2'b10:   pending_d = pending_q + (AW+1)'(1);
            2'b01:   pending_d = pending_q - (AW+1)'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign rsv_ready = ready_s;
    assign pending   = pending_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Register file with integrated write scoreboard. Two combinational read
// ports with write bypass, one synchronous write port, r0 hardwired to zero.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   rs1_addr/rs1_data/rs1_busy     : read port 1 index, data, pending flag
//   rs2_addr/rs2_data/rs2_busy     : read port 2 index, data, pending flag
//   wenable, waddr, wdata          : write port
//   rsv_valid, rsv_addr, rsv_ready : destination reservation handshake
//   pending                        : number of registers awaiting writeback
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [BITS-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [BITS-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            wenable,
    input  logic [AW-1:0]   waddr,
    input  logic [BITS-1:0] wdata,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ready,
    output logic [AW:0]     pending
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [BITS-1:0] regs_q [NREGS];
    logic [BITS-1:0] rs1_data_s;
    logic [BITS-1:0] rs2_data_s;
    logic            wr_en_s;

    assign wr_en_s = wenable && (waddr != ZERO_IDX);

    // Storage array; r0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {BITS{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read port 1: zero register, then same-cycle write bypass, then storage.
    always_comb begin
        if (rs1_addr == ZERO_IDX) begin
            rs1_data_s = {BITS{1'b0}};
        end else if (wenable && (waddr == rs1_addr)) begin
            rs1_data_s = wdata;
        end else begin
            rs1_data_s = regs_q[rs1_addr];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if (rs2_addr == ZERO_IDX) begin
            rs2_data_s = {BITS{1'b0}};
        end else if (wenable && (waddr == rs2_addr)) begin
            rs2_data_s = wdata;
        end else begin
            rs2_data_s = regs_q[rs2_addr];
        end
    end

    assign rs1_data = rs1_data_s;
    assign rs2_data = rs2_data_s;

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_busy  (rs2_busy),
        .wenable   (wenable),
        .waddr     (waddr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .pending   (pending)
    );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, a hand-written
// mid-operation reset sequence, and randomized traffic against a reference
// model of the register contents and the set of busy registers.
module tb_reg_file_sb;

    localparam int BITS  = 8;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1_addr;
    logic [BITS-1:0] rs1_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_addr;
    logic [BITS-1:0] rs2_data;
    logic            rs2_busy;
    logic            wenable;
    logic [AW-1:0]   waddr;
    logic [BITS-1:0] wdata;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ready;
    logic [AW:0]     pending;

    int checks = 0;
    int errors = 0;

    reg_file_sb #(
        .BITS  (BITS),
        .NREGS (NREGS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .rs2_busy  (rs2_busy),
        .wenable   (wenable),
        .waddr     (waddr),
        .wdata     (wdata),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            rst;
        logic            wen;
        logic [AW-1:0]   waddr;
        logic [BITS-1:0] wdata;
        logic            rv;
        logic [AW-1:0]   raddr;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic [BITS-1:0] e_d1;
        logic            e_b1;
        logic [BITS-1:0] e_d2;
        logic            e_b2;
        logic            e_rdy;
        logic [AW:0]     e_pend;
    } vec_t;

    vec_t tbl [21];

    // Reference model: register contents and which registers await a write.
    logic [BITS-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    function automatic vec_t mk(logic r, logic we, int wa, int wd, logic rv,
                                int ra, int a1, int a2, int d1, logic b1,
                                int d2, logic b2, logic rdy, int pnd);
        vec_t v;
        v.rst = r; v.wen = we; v.waddr = AW'(wa); v.wdata = BITS'(wd);
        v.rv = rv; v.raddr = AW'(ra); v.a1 = AW'(a1); v.a2 = AW'(a2);
        v.e_d1 = BITS'(d1); v.e_b1 = b1; v.e_d2 = BITS'(d2); v.e_b2 = b2;
        v.e_rdy = rdy; v.e_pend = (AW+1)'(pnd);
        return v;
    endfunction

    task automatic drive(logic r, logic we, int wa, int wd, logic rv, int ra,
                         int a1, int a2);
        rst = r; wenable = we; waddr = AW'(wa); wdata = BITS'(wd);
        rsv_valid = rv; rsv_addr = AW'(ra);
        rs1_addr = AW'(a1); rs2_addr = AW'(a2);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BITS-1:0] m_data(logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wenable && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_isbusy(logic [AW-1:0] a);
        return m_busy[a] && !(wenable && waddr == a);
    endfunction

    function automatic logic m_ready();
        return !m_busy[rsv_addr] || (wenable && waddr == rsv_addr);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_checks(string tag);
        check({tag, "_d1"}, 32'(rs1_data), 32'(m_data(rs1_addr)));
        check({tag, "_b1"}, 32'(rs1_busy), 32'(m_isbusy(rs1_addr)));
        check({tag, "_d2"}, 32'(rs2_data), 32'(m_data(rs2_addr)));
        check({tag, "_b2"}, 32'(rs2_busy), 32'(m_isbusy(rs2_addr)));
        check({tag, "_rdy"}, 32'(rsv_ready), 32'(m_ready()));
        check({tag, "_pend"}, 32'(pending), 32'(m_count()));
    endtask

    // Clock one edge and apply the architectural rules to the model.
    task automatic edge_model();
        logic acc;
        @(posedge clk);
        acc = rsv_valid && m_ready();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wenable && waddr != 0) m_regs[waddr] = wdata;
            if (wenable) m_busy[waddr] = 1'b0;
            if (acc && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        // Directed vectors: inputs, then outputs expected before the edge.
        //              rst we wa wd    rv ra a1 a2  d1    b1 d2    b2 rdy pnd
        tbl[0]  = mk(0, 0, 0, 0,     0, 0, 3, 0, 0,    0, 0,    0, 1, 0);
        tbl[1]  = mk(0, 1, 5, 'hA5,  0, 0, 5, 0, 'hA5, 0, 0,    0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0,     0, 0, 5, 0, 'hA5, 0, 0,    0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 'hFF,  0, 0, 0, 5, 0,    0, 'hA5, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,     1, 3, 3, 0, 0,    0, 0,    0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0,     1, 3, 3, 0, 0,    1, 0,    0, 0, 1);
        tbl[6]  = mk(0, 1, 3, 'h3C,  0, 3, 3, 3, 'h3C, 0, 'h3C, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0,     0, 3, 3, 0, 'h3C, 0, 0,    0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,     1, 4, 4, 0, 0,    0, 0,    0, 1, 0);
        tbl[9]  = mk(0, 1, 4, 'h5A,  1, 4, 4, 4, 'h5A, 0, 'h5A, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0,     0, 4, 4, 4, 'h5A, 1, 'h5A, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0,     1, 1, 1, 0, 0,    0, 0,    0, 1, 1);
        tbl[12] = mk(0, 0, 0, 0,     1, 2, 2, 0, 0,    0, 0,    0, 1, 2);
        tbl[13] = mk(0, 0, 0, 0,     1, 3, 3, 0, 'h3C, 0, 0,    0, 1, 3);
        tbl[14] = mk(0, 0, 0, 0,     1, 4, 4, 0, 'h5A, 1, 0,    0, 0, 4);
        tbl[15] = mk(0, 0, 0, 0,     1, 5, 5, 0, 'hA5, 0, 0,    0, 1, 4);
        tbl[16] = mk(0, 0, 0, 0,     1, 6, 6, 0, 0,    0, 0,    0, 1, 5);
        tbl[17] = mk(0, 0, 0, 0,     1, 7, 7, 0, 0,    0, 0,    0, 1, 6);
        tbl[18] = mk(0, 0, 0, 0,     1, 0, 0, 7, 0,    0, 0,    1, 1, 7);
        tbl[19] = mk(0, 0, 0, 0,     0, 0, 1, 0, 0,    1, 0,    0, 1, 7);
        tbl[20] = mk(0, 0, 0, 0,     0, 0, 7, 3, 0,    1, 'h3C, 1, 1, 7);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        edge_model();

        // Reset state: every address reads zero and not busy.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(NREGS - 1 - a);
            #1;
            check($sformatf("rst_d1_a%0d", a), 32'(rs1_data), 32'h0);
            check($sformatf("rst_b1_a%0d", a), 32'(rs1_busy), 32'h0);
            check($sformatf("rst_d2_a%0d", a), 32'(rs2_data), 32'h0);
            check($sformatf("rst_b2_a%0d", a), 32'(rs2_busy), 32'h0);
        end
        check("rst_pend", 32'(pending), 32'h0);
        check("rst_rdy", 32'(rsv_ready), 32'h1);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].wen, int'(tbl[i].waddr), int'(tbl[i].wdata),
                  tbl[i].rv, int'(tbl[i].raddr), int'(tbl[i].a1), int'(tbl[i].a2));
            #1;
            check($sformatf("vec%0d_d1", i), 32'(rs1_data), 32'(tbl[i].e_d1));
            check($sformatf("vec%0d_b1", i), 32'(rs1_busy), 32'(tbl[i].e_b1));
            check($sformatf("vec%0d_d2", i), 32'(rs2_data), 32'(tbl[i].e_d2));
            check($sformatf("vec%0d_b2", i), 32'(rs2_busy), 32'(tbl[i].e_b2));
            check($sformatf("vec%0d_rdy", i), 32'(rsv_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_pend", i), 32'(pending), 32'(tbl[i].e_pend));
            edge_model();
        end

        // Mid-operation reset with a write presented in the reset cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        edge_model();
        drive(0, 1, 2, 'h11, 0, 0, 0, 0);
        edge_model();
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        edge_model();
        drive(0, 0, 0, 0, 1, 6, 0, 0);
        edge_model();
        drive(0, 0, 0, 0, 0, 0, 2, 6);
        #1;
        check("mid_pre_d1", 32'(rs1_data), 32'h11);
        check("mid_pre_b1", 32'(rs1_busy), 32'h1);
        check("mid_pre_b2", 32'(rs2_busy), 32'h1);
        check("mid_pre_pend", 32'(pending), 32'h2);
        drive(1, 1, 2, 'h22, 1, 5, 0, 0);
        edge_model();
        drive(0, 0, 0, 0, 0, 2, 2, 6);
        #1;
        check("mid_post_d1", 32'(rs1_data), 32'h0);
        check("mid_post_b1", 32'(rs1_busy), 32'h0);
        check("mid_post_b2", 32'(rs2_busy), 32'h0);
        check("mid_post_pend", 32'(pending), 32'h0);
        check("mid_post_rdy", 32'(rsv_ready), 32'h1);
        rsv_addr = 3'd5;
        #1;
        check("mid_post_rdy5", 32'(rsv_ready), 32'h1);
        edge_model();

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, NREGS - 1)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, NREGS - 1)),
                  int'($urandom_range(0, NREGS - 1)),
                  int'($urandom_range(0, NREGS - 1)));
            #1;
            model_checks($sformatf("rnd%0d", n));
            edge_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_sb
